aes_enc_stream_pipe: RTL and testbench
======================================

Name: aes_enc_stream_pipe

Overview:
- Fully unrolled, pipelined AES encryption core with a valid/ready stream interface on input and output.
- Global-stall backpressure; a TAG_W-bit sideband travels with each block in lockstep.
- Internal round-key register bank, reloaded through a handshake that first drains the pipeline.
- Sits between the AXI slave front end (block in, key in) and the output stream buffer. Supports AES-128/192/256 by parameter.

Parameters:
- NR, 10, number of rounds; legal values 10, 12, 14; any other value is an elaboration error.
- TAG_W, 8, sideband width carried alongside each block; minimum 1.
- LAT, 2*NR+1, derived localparam; accept-to-output latency in cycles with no stall.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  plaintext block offered.
- in_ready  output  1  core accepts block this cycle.
- in_data  input  128  plaintext.
- in_tag  input  TAG_W  sideband for in_data.
- key_valid  input  1  new key schedule offered.
- key_ready  output  1  key schedule accepted this cycle.
- round_keys_flat  input  (NR+1)*128  rk[k] at bits [k*128 +: 128].
- out_valid  output  1  ciphertext available.
- out_ready  input  1  downstream accepts.
- out_data  output  128  ciphertext.
- out_tag  output  TAG_W  tag of out_data.
- busy  output  1  occupancy != 0.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All valid bits, the occupancy counter and the round-key bank clear to 0.
  - out_valid=0, out_data=0, out_tag=0, busy=0, key_ready=0.
  - in_ready=0 while rst_n=0.
  - A reset mid-operation discards all in-flight blocks; no output follows.
- Pipeline stages:
  - S0 registers in_data ^ rk[0].
  - Each round r (1..NR) has two registered stages: A = SubBytes+ShiftRows, B = MixColumns (omitted when r=NR) + AddRoundKey rk[r].
  - Total LAT register stages. Each stage carries a valid bit and the tag.
- Advance: adv = ~out_valid | out_ready.
  - When adv=1, every stage shifts by one, bubbles included.
  - When adv=0, every stage holds.
  - Bubbles are not compressed.
- Input acceptance:
  - in_ready = adv & ~key_valid.
  - A block is accepted when in_valid & in_ready; its S0 valid bit = 1.
  - Otherwise a bubble enters S0 on adv.
- Latency:
  - A block accepted in cycle t appears with out_valid=1 in cycle t+LAT if adv stays 1 throughout.
  - Each stall cycle adds exactly one cycle.
- Output holding:
  - While out_valid=1 and out_ready=0, out_data and out_tag hold stable.
  - Ordering is strictly FIFO.
  - Full throughput is one block per cycle.
- Occupancy counter (width $clog2(LAT+1)):
  - +1 on accept, −1 on out_valid&out_ready; simultaneous events leave it unchanged.
  - Never exceeds LAT.
- Key load:
  - key_ready = key_valid & (occupancy==0).
  - Handshake when key_valid & key_ready; round_keys_flat is latched into the bank that edge.
  - While key_valid=1, in_ready=0, so the pipeline drains and no block is accepted in the load cycle.
  - Blocks already in flight always use the bank contents present at their acceptance; this holds because a load can only happen when occupancy==0.
  - Keys are sampled from round_keys_flat only on the key handshake; changes at any other time are ignored.
- Empty pipeline: out_valid=0, busy=0, in_ready=~key_valid.
- Full pipeline with out_ready=0: in_ready=0. No data is lost and none is duplicated.

Decomposition:
- Shared package aes_pkg:
  - SBOX function (or ROM constant).
  - xtime/gf_mul2 and mix_column functions.
  - shift_rows function.
  - Constants BLK_W=128 and the legal NR set.
- Sub-module aes_round_2stage_en: one round (stages A and B).
  - Ports: en, valid_in/out, tag_in/out, state_in/out, round_key, last_round.
  - Instantiated NR times via generate.
- Top level holds S0, the key bank, adv/ready logic and the occupancy counter.

Test Plan:
- NR=10: load key 000102…0f expanded; send pt 00112233445566778899aabbccddeeff, tag 0x5A, out_ready=1 -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_tag 0x5A, exactly 21 cycles after accept.
- NR=14: key 000102…1f, same pt -> 8ea2b7ca516745bfeafc49904b496089, latency 29. NR=12: key 000102…17 -> dda97ca4864cdfe06eaf70a0ec0d7191, latency 25.
- Back-to-back: 64 random blocks, tags 0..63, with random out_ready at 50% -> ciphertexts match the model in order; no tag is skipped or duplicated; out_data is stable while stalled.
- Key change with 5 blocks in flight: assert key_valid -> in_ready drops the same cycle; key_ready rises only after the 5th output handshake; the next block encrypts under the new key.
- Full-pipe stall: out_ready=0 until occupancy=21 (NR=10) -> in_ready=0 and busy=1; release -> all 21 blocks are emitted on 21 consecutive cycles.
- Reset at cycle 7 of a 10-block burst -> out_valid=0 with no output afterward; occupancy=0; a post-reset key load and encryption of the FIPS vector passes.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, legal round counts and the byte-level
// transforms used by every round stage. Byte 0 of a block sits in bits [127:120].
package aes_pkg;

  localparam int BLK_W = 128;
  localparam int NR_AES128 = 10;
  localparam int NR_AES192 = 12;
  localparam int NR_AES256 = 14;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic bit nr_is_legal(input int nr);
    return (nr == NR_AES128) || (nr == NR_AES192) || (nr == NR_AES256);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row 0 of the column is the most significant byte.
  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [BLK_W-1:0] sub_bytes(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] r;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = sbox(s[8*i +: 8]);
    end
    return r;
  endfunction

  function automatic logic [BLK_W-1:0] shift_rows(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] r;
    for (int col = 0; col < 4; col++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(row+4*col) -: 8] = s[127-8*(row+4*((col+row)%4)) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [BLK_W-1:0] mix_columns(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] r;
    for (int col = 0; col < 4; col++) begin
      r[127-32*col -: 32] = mix_column(s[127-32*col -: 32]);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_round_2stage_en.sv
// One AES round split over two registered stages (SubBytes+ShiftRows, then
// MixColumns+AddRoundKey); valid and tag move in lockstep, all stages gated by en.
module aes_round_2stage_en
  import aes_pkg::*;
#(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             valid_in,
  input  logic [TAG_W-1:0] tag_in,
  input  logic [BLK_W-1:0] state_in,
  input  logic [BLK_W-1:0] round_key,
  input  logic             last_round,
  output logic             valid_out,
  output logic [TAG_W-1:0] tag_out,
  output logic [BLK_W-1:0] state_out
);

  logic             a_valid_q, b_valid_q;
  logic [TAG_W-1:0] a_tag_q, b_tag_q;
  logic [BLK_W-1:0] a_state_q, b_state_q;
  logic [BLK_W-1:0] a_state_d, b_state_d;

  always_comb begin
    a_state_d = shift_rows(sub_bytes(state_in));
    if (last_round) begin
      b_state_d = a_state_q ^ round_key;
    end else begin
      b_state_d = mix_columns(a_state_q) ^ round_key;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q <= 1'b0;
      a_tag_q   <= '0;
      a_state_q <= '0;
      b_valid_q <= 1'b0;
      b_tag_q   <= '0;
      b_state_q <= '0;
    end else if (en) begin
      a_valid_q <= valid_in;
      a_tag_q   <= tag_in;
      a_state_q <= a_state_d;
      b_valid_q <= a_valid_q;
      b_tag_q   <= a_tag_q;
      b_state_q <= b_state_d;
    end
  end

  assign valid_out = b_valid_q;
  assign tag_out   = b_tag_q;
  assign state_out = b_state_q;

endmodule

// File: rtl/aes_enc_stream_pipe.sv
// Fully unrolled AES encryption pipeline with a global-stall stream interface,
// a tag sideband and a round-key bank that only reloads once the pipe is empty.
module aes_enc_stream_pipe
  import aes_pkg::*;
#(
  parameter int NR    = 10,
  parameter int TAG_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BLK_W-1:0]        in_data,
  input  logic [TAG_W-1:0]        in_tag,
  input  logic                    key_valid,
  output logic                    key_ready,
  input  logic [(NR+1)*BLK_W-1:0] round_keys_flat,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BLK_W-1:0]        out_data,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    busy
);

  localparam int LAT   = 2 * NR + 1;
  localparam int OCC_W = $clog2(LAT + 1);
  localparam logic [OCC_W-1:0] OCC_ONE = {{(OCC_W-1){1'b0}}, 1'b1};

  if (!nr_is_legal(NR)) begin : g_bad_nr
    $error("aes_enc_stream_pipe: NR must be 10, 12 or 14");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("aes_enc_stream_pipe: TAG_W must be at least 1");
  end

  logic                    s0_valid_q;
  logic [TAG_W-1:0]        s0_tag_q;
  logic [BLK_W-1:0]        s0_state_q;
  logic [(NR+1)*BLK_W-1:0] rk_bank_q;
  logic [OCC_W-1:0]        occ_q, occ_d;

  logic adv_s, accept_s, emit_s, key_load_s;

  logic [NR:0]             valid_c;
  logic [NR:0][TAG_W-1:0]  tag_c;
  logic [NR:0][BLK_W-1:0]  state_c;

  // One global enable: the whole pipe moves unless the output is stuck.
  assign adv_s      = ~out_valid | out_ready;
  assign in_ready   = rst_n & adv_s & ~key_valid;
  assign key_ready  = rst_n & key_valid & (occ_q == '0);
  assign accept_s   = in_valid & in_ready;
  assign emit_s     = out_valid & out_ready;
  assign key_load_s = key_valid & key_ready;

  always_comb begin
    case ({accept_s, emit_s})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_q <= 1'b0;
      s0_tag_q   <= '0;
      s0_state_q <= '0;
      rk_bank_q  <= '0;
      occ_q      <= '0;
    end else begin
      occ_q <= occ_d;
      if (adv_s) begin
        s0_valid_q <= accept_s;
        s0_tag_q   <= in_tag;
        s0_state_q <= in_data ^ rk_bank_q[BLK_W-1:0];
      end
      // Occupancy is zero here, so no in-flight block sees the new keys.
      if (key_load_s) begin
        rk_bank_q <= round_keys_flat;
      end
    end
  end

  assign valid_c[0] = s0_valid_q;
  assign tag_c[0]   = s0_tag_q;
  assign state_c[0] = s0_state_q;

  for (genvar r = 1; r <= NR; r++) begin : g_round
    aes_round_2stage_en #(
      .TAG_W(TAG_W)
    ) u_round (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (adv_s),
      .valid_in  (valid_c[r-1]),
      .tag_in    (tag_c[r-1]),
      .state_in  (state_c[r-1]),
      .round_key (rk_bank_q[r*BLK_W +: BLK_W]),
      .last_round((r == NR) ? 1'b1 : 1'b0),
      .valid_out (valid_c[r]),
      .tag_out   (tag_c[r]),
      .state_out (state_c[r])
    );
  end

  assign out_valid = valid_c[NR];
  assign out_tag   = tag_c[NR];
  assign out_data  = state_c[NR];
  assign busy      = (occ_q != '0);

endmodule

// File: tb/tb_aes_enc_stream_pipe.sv
// Randomised bench for aes_enc_stream_pipe: a byte-array AES model with a
// GF(2^8)-derived S-box feeds an in-order scoreboard that also tracks latency.
module tb_aes_enc_stream_pipe;

  localparam int NR    = 10;
  localparam int TAG_W = 8;
  localparam int LAT   = 2 * NR + 1;
  localparam int NK    = NR - 6;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = (NR == 14) ? 128'h8ea2b7ca516745bfeafc49904b496089 :
                                     (NR == 12) ? 128'hdda97ca4864cdfe06eaf70a0ec0d7191 :
                                                  128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    in_valid, in_ready, key_valid, key_ready;
  logic                    out_valid, out_ready, busy;
  logic [127:0]            in_data, out_data;
  logic [TAG_W-1:0]        in_tag, out_tag;
  logic [(NR+1)*128-1:0]   round_keys_flat;

  always #5 clk = ~clk;

  aes_enc_stream_pipe #(.NR(NR), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .key_valid(key_valid), .key_ready(key_ready), .round_keys_flat(round_keys_flat),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .busy(busy)
  );

  typedef struct {
    logic [127:0]     ct;
    logic [TAG_W-1:0] tag;
    int               age;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_out = 0;
  int last_acc_cyc = 0;
  int last_out_cyc = 0;
  bit acc_f, ohs_f, khs_f;
  logic hold_pend = 1'b0;
  logic [127:0] held_d, last_out_data;
  logic [TAG_W-1:0] held_t, last_out_tag;
  logic [7:0] sb_tab [256];
  logic [127:0] m_rk [0:NR];
  logic [127:0] p_rk [0:NR];
  exp_t q[$];

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb_tab[w[31:24]], sb_tab[w[23:16]], sb_tab[w[15:8]], sb_tab[w[7:0]]};
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] ct;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ m_rk[0][127-8*i -: 8];
    for (int r = 1; r <= NR; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb_tab[s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]];
      for (int c = 0; c < 4; c++) begin
        for (int w = 0; w < 4; w++) begin
          if (r < NR)
            s[4*c+w] = gmul(8'h02, t[4*c+w]) ^ gmul(8'h03, t[4*c+(w+1)%4]) ^
                       t[4*c+(w+2)%4] ^ t[4*c+(w+3)%4];
          else
            s[4*c+w] = t[4*c+w];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ m_rk[r][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
    return ct;
  endfunction

  task automatic expand(input logic [255:0] key);
    logic [31:0] w [0:59];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < NK; i++) w[i] = key[255-32*i -: 32];
    for (int i = NK; i < 4 * (NR + 1); i++) begin
      tmp = w[i-1];
      if (i % NK == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (NK > 6 && i % NK == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-NK] ^ tmp;
    end
    for (int k = 0; k <= NR; k++) p_rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One clock: observe and score at the falling edge, return just after the rising edge.
  task automatic cycle();
    logic exp_ov, adv;
    exp_t e;
    @(negedge clk);
    acc_f = 1'b0; ohs_f = 1'b0; khs_f = 1'b0;
    if (rst_n) begin
      exp_ov = (q.size() > 0) && (q[0].age >= LAT);
      chk("out_valid", 136'(out_valid), 136'(exp_ov));
      adv = !out_valid || out_ready;
      chk("in_ready", 136'(in_ready), 136'(adv && !key_valid));
      chk("key_ready", 136'(key_ready), 136'(key_valid && q.size() == 0));
      chk("busy", 136'(busy), 136'(q.size() != 0));
      if (hold_pend) chk("hold_stable", {out_tag, out_data}, {held_t, held_d});
      hold_pend = out_valid && !out_ready;
      held_d = out_data;
      held_t = out_tag;
      if (out_valid && out_ready) begin
        ohs_f = 1'b1; n_out++; last_out_cyc = cyc;
        last_out_data = out_data; last_out_tag = out_tag;
        if (q.size() == 0) begin
          chk("spurious_out", 136'(out_valid), 136'(0));
        end else begin
          e = q.pop_front();
          chk("out_data", 136'(out_data), 136'(e.ct));
          chk("out_tag", 136'(out_tag), 136'(e.tag));
        end
      end
      if (in_valid && in_ready) begin
        acc_f = 1'b1; last_acc_cyc = cyc;
        e.ct = model_enc(in_data); e.tag = in_tag; e.age = 0;
        q.push_back(e);
      end
      if (adv) for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
      if (key_valid && key_ready) begin
        khs_f = 1'b1;
        for (int k = 0; k <= NR; k++) m_rk[k] = p_rk[k];
      end
    end else begin
      hold_pend = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    q.delete();
    hold_pend = 1'b0;
    for (int k = 0; k <= NR; k++) m_rk[k] = '0;
    key_valid = 1'b1;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 136'(out_valid), 136'(0));
    chk("rst_out_data", 136'(out_data), 136'(0));
    chk("rst_out_tag", 136'(out_tag), 136'(0));
    chk("rst_busy", 136'(busy), 136'(0));
    chk("rst_key_ready", 136'(key_ready), 136'(0));
    chk("rst_in_ready", 136'(in_ready), 136'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    key_valid = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic load_key(input logic [255:0] key);
    int n;
    expand(key);
    for (int k = 0; k <= NR; k++) round_keys_flat[k*128 +: 128] = p_rk[k];
    key_valid = 1'b1;
    n = 0;
    khs_f = 1'b0;
    while (!khs_f && n < 300) begin cycle(); n++; end
    chk("key_handshake", 136'(khs_f), 136'(1));
    key_valid = 1'b0;
    for (int k = 0; k <= NR; k++) round_keys_flat[k*128 +: 128] = rand128();
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (q.size() > 0 && n < 500) begin cycle(); n++; end
    chk("drain_busy", 136'(busy), 136'(0));
  endtask

  task automatic fips_test();
    logic [255:0] key;
    int n;
    key = '0;
    for (int j = 0; j < 4 * NK; j++) key[255-8*j -: 8] = 8'(j);
    load_key(key);
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = FIPS_PT; in_tag = 8'h5a;
    cycle();
    chk("fips_accept", 136'(acc_f), 136'(1));
    in_valid = 1'b0; in_data = rand128();
    n = 0;
    ohs_f = 1'b0;
    while (!ohs_f && n < 200) begin cycle(); n++; end
    chk("fips_out_seen", 136'(ohs_f), 136'(1));
    chk("fips_ct", 136'(last_out_data), 136'(FIPS_CT));
    chk("fips_tag", 136'(last_out_tag), 136'(8'h5a));
    chk("fips_latency", 136'(last_out_cyc - last_acc_cyc), 136'(LAT));
  endtask

  initial begin
    int idx, n, base;
    build_sbox();
    rst_n = 1'b1; in_valid = 1'b0; in_data = '0; in_tag = '0;
    key_valid = 1'b0; round_keys_flat = '0; out_ready = 1'b1;
    #2;
    apply_reset();

    fips_test();

    // Back-to-back random blocks with random backpressure.
    load_key({rand128(), rand128()});
    base = n_out; idx = 0; n = 0;
    while (idx < 64 && n < 3000) begin
      in_valid = 1'b1; in_data = rand128(); in_tag = TAG_W'(idx);
      out_ready = 1'($urandom_range(0, 1));
      cycle();
      if (acc_f) idx++;
      n++;
    end
    in_valid = 1'b0; n = 0;
    while (q.size() > 0 && n < 3000) begin out_ready = 1'($urandom_range(0, 1)); cycle(); n++; end
    chk("b2b_count", 136'(n_out - base), 136'(64));
    drain();

    // Key change with five blocks in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = rand128(); in_tag = TAG_W'(100 + i);
      cycle();
    end
    base = n_out;
    in_data = rand128(); in_tag = 8'hc3;
    load_key({rand128(), rand128()});
    chk("keychg_outs_before_load", 136'(n_out - base), 136'(5));
    cycle();
    chk("keychg_post_accept", 136'(acc_f), 136'(1));
    drain();

    // Fill the pipe completely while the output is blocked.
    out_ready = 1'b0; n = 0;
    while (q.size() < LAT && n < 200) begin
      in_valid = 1'b1; in_data = rand128(); in_tag = TAG_W'($urandom);
      cycle(); n++;
    end
    repeat (3) cycle();
    chk("full_busy", 136'(busy), 136'(1));
    chk("full_in_ready", 136'(in_ready), 136'(0));
    chk("full_out_valid", 136'(out_valid), 136'(1));
    in_valid = 1'b0; out_ready = 1'b1; base = n_out;
    repeat (LAT) cycle();
    chk("full_burst_count", 136'(n_out - base), 136'(LAT));
    chk("full_burst_empty", 136'(busy), 136'(0));

    // Reset in the middle of a burst discards everything in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 7) begin
        apply_reset();
        break;
      end
      in_valid = 1'b1; in_data = rand128(); in_tag = TAG_W'(i);
      cycle();
    end
    in_valid = 1'b0; base = n_out;
    repeat (30) cycle();
    chk("post_reset_no_output", 136'(n_out - base), 136'(0));
    chk("post_reset_busy", 136'(busy), 136'(0));

    // A block before any key load sees the cleared (all-zero) bank.
    in_valid = 1'b1; in_data = rand128(); in_tag = 8'h33;
    cycle();
    drain();

    fips_test();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
